// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: captures each instruction retired in WB once,
// queues it in a FIFO for an external trace consumer and stops capturing
// after the end-of-test syscall. Once that syscall has drained, done is raised.
module retire_trace_buffer #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] EXIT_CODE = 32'h0000_000A
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_valid,
   input  logic [31:0]   wb_pc,
   input  logic [31:0]   wb_instr,
   input  logic          wb_reg_write,
   input  logic [4:0]    wb_dest,
   input  logic [31:0]   wb_data,
   input  logic [31:0]   reg_v0,
   output logic          trace_valid,
   input  logic          trace_ready,
   output logic [101:0]  trace_data,
   output logic [31:0]   retire_count,
   output logic [7:0]    drop_count,
   output logic          overflow,
   output logic          done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 102;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q;
   logic            done_q;

   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic            armed_q;
   logic            hist_vld_q, hist_vld_d;
   logic [31:0]     hist_pc_q, hist_pc_d;
   logic [31:0]     hist_instr_q, hist_instr_d;

   logic [31:0]     retire_q, retire_d;
   logic [7:0]      drop_q, drop_d;
   logic            ovf_q, ovf_d;

   logic            empty, full, pop, push, drop, dup, capture, exit_hit;
   logic [EW-1:0]   entry;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop      = !empty && trace_ready;
   assign dup      = hist_vld_q && (wb_pc == hist_pc_q) && (wb_instr == hist_instr_q);
   assign capture  = armed_q && wb_valid && (wb_instr != '0) && !dup && (state_q == S_RUN);
   assign push     = capture && (!full || pop);
   assign drop     = capture && full && !pop;
   assign exit_hit = capture && (wb_instr == 32'h0000_000C) && (reg_v0 == EXIT_CODE);
   assign entry    = {wb_pc, wb_instr, wb_reg_write & (wb_dest != 5'd0), wb_dest, wb_data};

   assign trace_valid  = !empty;
   assign trace_data   = mem_q[rd_ptr_q[AW-1:0]];
   assign retire_count = retire_q;
   assign drop_count   = drop_q;
   assign overflow     = ovf_q;
   assign done         = done_q;

   // Next-state for pointers, duplicate history and statistics counters.
   always_comb begin
      wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
      // History stays live for as long as WB keeps presenting the same
      // instruction, so a stall of any length retires exactly once.
      hist_vld_d   = capture || (dup && wb_valid);
      hist_pc_d    = capture ? wb_pc    : hist_pc_q;
      hist_instr_d = capture ? wb_instr : hist_instr_q;
      retire_d     = retire_q + {31'd0, capture};
      drop_d       = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
      ovf_d        = ovf_q || drop;
   end

   // Pointer, history and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         armed_q      <= 1'b0;
         hist_vld_q   <= 1'b0;
         hist_pc_q    <= '0;
         hist_instr_q <= '0;
         retire_q     <= '0;
         drop_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         armed_q      <= 1'b1;
         hist_vld_q   <= hist_vld_d;
         hist_pc_q    <= hist_pc_d;
         hist_instr_q <= hist_instr_d;
         retire_q     <= retire_d;
         drop_q       <= drop_d;
         ovf_q        <= ovf_d;
      end
   end

   // FIFO storage; contents are abandoned on reset via the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= entry;
      end
   end

   // Run/drain/done sequencing with registered done flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RUN;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (exit_hit) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= S_RUN;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (DEPTH=8, EXIT_CODE=0xA).
module tb_retire_trace_buffer;

   logic          clk;
   logic          reset;
   logic          wb_valid;
   logic [31:0]   wb_pc;
   logic [31:0]   wb_instr;
   logic          wb_reg_write;
   logic [4:0]    wb_dest;
   logic [31:0]   wb_data;
   logic [31:0]   reg_v0;
   logic          trace_valid;
   logic          trace_ready;
   logic [101:0]  trace_data;
   logic [31:0]   retire_count;
   logic [7:0]    drop_count;
   logic          overflow;
   logic          done;

   int unsigned   total_cnt;
   int unsigned   pass_cnt;

   retire_trace_buffer #(
      .DEPTH     (8),
      .EXIT_CODE (32'h0000_000A)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_valid     (wb_valid),
      .wb_pc        (wb_pc),
      .wb_instr     (wb_instr),
      .wb_reg_write (wb_reg_write),
      .wb_dest      (wb_dest),
      .wb_data      (wb_data),
      .reg_v0       (reg_v0),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_data   (trace_data),
      .retire_count (retire_count),
      .drop_count   (drop_count),
      .overflow     (overflow),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [101:0] obs, input logic [101:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic rw, input logic [4:0] d, input logic [31:0] data);
      wb_valid     = v;
      wb_pc        = pc;
      wb_instr     = instr;
      wb_reg_write = rw;
      wb_dest      = d;
      wb_data      = data;
   endtask

   function automatic logic [101:0] ent(input logic [31:0] pc, input logic [31:0] instr,
                                        input logic rw, input logic [4:0] d,
                                        input logic [31:0] data);
      return {pc, instr, rw & (d != 5'd0), d, data};
   endfunction

   function automatic logic [101:0] gen(input int unsigned i);
      return ent(32'h1000 + 32'(i) * 4, 32'h2400_0001 + 32'(i), 1'b1, 5'(i), 32'(i) * 3);
   endfunction

   task automatic drive_gen(input int unsigned i);
      drive(1'b1, 32'h1000 + 32'(i) * 4, 32'h2400_0001 + 32'(i), 1'b1, 5'(i), 32'(i) * 3);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      total_cnt   = 0;
      pass_cnt    = 0;
      reset       = 1'b1;
      trace_ready = 1'b0;
      reg_v0      = 32'd0;
      drive(1'b0, '0, '0, 1'b0, '0, '0);

      // Reset state, asserted between clock edges
      #1 reset = 1'b0;
      #1;
      chk("rst_valid",   102'(trace_valid),  102'(0));
      chk("rst_retire",  102'(retire_count), 102'(0));
      chk("rst_drop",    102'(drop_count),   102'(0));
      chk("rst_ovf",     102'(overflow),     102'(0));
      chk("rst_done",    102'(done),         102'(0));
      tick();
      reset = 1'b1;
      tick();
      tick();

      // Single capture, then pop
      trace_ready = 1'b1;
      drive(1'b1, 32'h0040_0000, 32'h2002_0005, 1'b1, 5'd2, 32'd5);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      chk("single_valid",  102'(trace_valid),  102'(1));
      chk("single_data",   trace_data,
          {32'h0040_0000, 32'h2002_0005, 1'b1, 5'd2, 32'd5});
      chk("single_retire", 102'(retire_count), 102'(1));
      tick();
      chk("single_popped", 102'(trace_valid),  102'(0));

      // Stall-held instruction retires once
      trace_ready = 1'b0;
      drive(1'b1, 32'h0040_0004, 32'h8C03_0000, 1'b1, 5'd3, 32'd7);
      tick(); tick(); tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      chk("dup_retire", 102'(retire_count), 102'(2));
      chk("dup_valid",  102'(trace_valid),  102'(1));
      chk("dup_data",   trace_data, ent(32'h0040_0004, 32'h8C03_0000, 1'b1, 5'd3, 32'd7));
      trace_ready = 1'b1;
      tick();
      chk("dup_one_entry", 102'(trace_valid), 102'(0));

      // Overflow: 10 captures into 8 slots with consumer stalled
      trace_ready = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         drive_gen(i);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      chk("ovf_flag",   102'(overflow),     102'(1));
      chk("ovf_drop",   102'(drop_count),   102'(2));
      chk("ovf_retire", 102'(retire_count), 102'(12));
      trace_ready = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         chk($sformatf("ovf_drain_valid%0d", k), 102'(trace_valid), 102'(1));
         chk($sformatf("ovf_drain_data%0d", k),  trace_data, gen(k));
         tick();
      end
      chk("ovf_empty", 102'(trace_valid), 102'(0));

      // Full with simultaneous pop: no drop
      do_reset();
      trace_ready = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         drive_gen(i);
         tick();
      end
      trace_ready = 1'b1;
      drive_gen(8);
      tick();
      trace_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      chk("fullpop_ovf",    102'(overflow),     102'(0));
      chk("fullpop_drop",   102'(drop_count),   102'(0));
      chk("fullpop_retire", 102'(retire_count), 102'(9));
      trace_ready = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         chk($sformatf("fullpop_valid%0d", k), 102'(trace_valid), 102'(1));
         chk($sformatf("fullpop_data%0d", k),  trace_data, gen(k + 1));
         tick();
      end
      chk("fullpop_empty", 102'(trace_valid), 102'(0));

      // Syscall with non-exit $v0 is ordinary
      reg_v0 = 32'd4;
      drive(1'b1, 32'h2000, 32'h0000_000C, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      chk("sys4_data", trace_data, ent(32'h2000, 32'h0000_000C, 1'b0, 5'd0, 32'd0));
      tick();
      tick();
      chk("sys4_done",   102'(done),         102'(0));
      chk("sys4_retire", 102'(retire_count), 102'(10));

      // Exit syscall with two entries ahead
      trace_ready = 1'b0;
      reg_v0 = 32'h0000_000A;
      drive(1'b1, 32'h3000, 32'h0000_0001, 1'b1, 5'd4, 32'h11);
      tick();
      drive(1'b1, 32'h3004, 32'h0000_0002, 1'b1, 5'd5, 32'h22);
      tick();
      drive(1'b1, 32'h3008, 32'h0000_000C, 1'b0, 5'd0, 32'h0);
      tick();
      drive(1'b1, 32'h300C, 32'h0000_0005, 1'b1, 5'd6, 32'h33);
      trace_ready = 1'b1;
      chk("exit_head0", trace_data, ent(32'h3000, 32'h0000_0001, 1'b1, 5'd4, 32'h11));
      tick();
      drive(1'b1, 32'h3010, 32'h0000_0006, 1'b1, 5'd7, 32'h44);
      chk("exit_head1", trace_data, ent(32'h3004, 32'h0000_0002, 1'b1, 5'd5, 32'h22));
      tick();
      chk("exit_head2", trace_data, ent(32'h3008, 32'h0000_000C, 1'b0, 5'd0, 32'h0));
      tick();
      chk("exit_empty",      102'(trace_valid),  102'(0));
      chk("exit_done_early", 102'(done),         102'(0));
      tick();
      chk("exit_done",       102'(done),         102'(1));
      chk("exit_retire",     102'(retire_count), 102'(13));
      tick(); tick();
      chk("exit_done_held",  102'(done),         102'(1));
      chk("exit_no_capture", 102'(trace_valid),  102'(0));
      drive(1'b0, '0, '0, 1'b0, '0, '0);

      // Async reset mid-drain with 5 entries queued
      do_reset();
      trace_ready = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         drive_gen(i);
         tick();
      end
      drive(1'b1, 32'h5000, 32'h0000_000C, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      trace_ready = 1'b1;
      tick(); tick(); tick();
      trace_ready = 1'b0;
      chk("mid_head",   trace_data,           gen(3));
      chk("mid_ovf",    102'(overflow),       102'(1));
      chk("mid_drop",   102'(drop_count),     102'(1));
      chk("mid_retire", 102'(retire_count),   102'(9));
      reset = 1'b0;
      #2;
      chk("arst_valid",  102'(trace_valid),  102'(0));
      chk("arst_retire", 102'(retire_count), 102'(0));
      chk("arst_drop",   102'(drop_count),   102'(0));
      chk("arst_ovf",    102'(overflow),     102'(0));
      chk("arst_done",   102'(done),         102'(0));
      tick();
      reset = 1'b1;
      tick();
      tick();
      chk("post_rst_valid", 102'(trace_valid), 102'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter EXIT_CODE, default 32'h0000000A, giving the $v0 value that marks end-of-test.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wb_valid, input, 1, WB stage holds a completed instruction this cycle.
REQ-006 SHALL have port wb_pc, input, 32, PC of the WB instruction.
REQ-007 SHALL have port wb_instr, input, 32, instruction word in WB.
REQ-008 SHALL have port wb_reg_write, input, 1, WB writes the register file this cycle.
REQ-009 SHALL have port wb_dest, input, 5, destination register number.
REQ-010 SHALL have port wb_data, input, 32, write-back data.
REQ-011 SHALL have port reg_v0, input, 32, current regfile[2] value.
REQ-012 SHALL have ports trace_valid (output, 1), trace_ready (input, 1), trace_data (output, 102: {pc, instr, reg_write, dest, data}, MSB first).
REQ-013 SHALL have outputs retire_count (32), drop_count (8), overflow (1), done (1).

Function
REQ-014 SHALL define capture = wb_valid & (wb_instr != 0) & not duplicate & state == RUN.
REQ-015 SHALL define duplicate as: the previous cycle was a capture with identical wb_pc and wb_instr (stall-held WB retires once).
REQ-016 SHALL push {wb_pc, wb_instr, wb_reg_write & (wb_dest != 0), wb_dest, wb_data} on capture when not full; data registered, visible no earlier than the next cycle (no bypass).
REQ-017 SHALL pop the head entry when trace_valid & trace_ready; trace_valid = not empty; trace_data = head entry, stable while trace_valid & !trace_ready.
REQ-018 SHALL accept push when full if a pop occurs in the same cycle; occupancy unchanged.
REQ-019 SHALL, on capture when full and no pop, discard the entry, set overflow (sticky), increment drop_count saturating at 255.
REQ-020 SHALL increment retire_count on every capture, including dropped ones; wraps 0xFFFFFFFF -> 0.
REQ-021 SHALL use read/write pointers of log2(DEPTH)+1 bits; full/empty from MSB comparison; pointers wrap modulo 2*DEPTH.
REQ-022 SHALL implement FSM states RUN, DRAIN, DONE.
REQ-023 RUN -> DRAIN when a capture has wb_instr == 32'h0000000C and reg_v0 == EXIT_CODE; the syscall entry itself is captured.
REQ-024 SHALL capture nothing in DRAIN or DONE; DRAIN -> DONE when FIFO empty; DONE held until reset.
REQ-025 SHALL drive done = 1 only in DONE.
REQ-026 A syscall with reg_v0 != EXIT_CODE SHALL be captured as an ordinary instruction, state stays RUN.

Reset
REQ-027 SHALL, while reset = 0, immediately force: state RUN, pointers 0, trace_valid 0, retire_count 0, drop_count 0, overflow 0, done 0, duplicate history cleared.
REQ-028 SHALL discard FIFO contents on reset mid-operation; trace_data value is don't-care while trace_valid = 0.
REQ-029 SHALL ignore all inputs on the first rising edge after reset deasserts only if it is within the same cycle as deassertion; capture resumes from the next edge.

Verification
REQ-030 Single capture: wb_valid=1, pc=0x400000, instr=0x20020005, reg_write=1, dest=2, data=5, ready=1 -> next cycle trace_valid=1, trace_data matches, retire_count=1; popped following edge.
REQ-031 Stall duplicate: same pc/instr held 3 cycles with wb_valid=1 -> exactly one entry, retire_count=1.
REQ-032 Overflow: ready=0, 10 distinct captures, DEPTH=8 -> 8 entries, overflow=1, drop_count=2, retire_count=10; then ready=1 drains 8 in order, first pc first.
REQ-033 Full with pop: FIFO full, capture and pop same cycle -> no drop, occupancy stays 8, overflow stays 0.
REQ-034 Exit: instr=0x0000000C, reg_v0=0xA, 2 entries ahead, ready=1 -> syscall entry emitted last, later wb_valid ignored, done=1 the cycle after FIFO empties; reg_v0=0x4 instead -> no done.
REQ-035 Async reset: assert reset=0 mid-drain with 5 entries -> trace_valid, counters, overflow, done drop to 0 without a clock edge.
